pixel_fifo_writer: RTL and testbench

PIXEL_FIFO_WRITER -- requirements
Module: pixel_fifo_writer

---
 rtl/pixel_fifo_writer_pkg.sv | 18 +
 rtl/pixel_skid_buf.sv | 29 ++
 rtl/pixel_fifo_writer.sv | 115 +++++++++++
 tb/tb_pixel_fifo_writer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fifo_writer_pkg.sv
// Shared DVI constants: default active geometry, frame-buffer address width,
// pixel width and the writer FSM encoding. Also used by the FIFO reader and
// timing logic so all blocks agree on frame size.
package pixel_fifo_writer_pkg;

  localparam int H_ACTIVE_DEF     = 640;
  localparam int V_ACTIVE_DEF     = 480;
  localparam int FRAME_PIXELS_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int ADDR_W_DEF       = 19;
  localparam int PIXEL_W          = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wr_state_t;

endpackage

// File: rtl/pixel_skid_buf.sv
// One-entry pixel holding register. It catches the ROM word that arrives
// while the display FIFO is refusing writes, so no read has to be replayed.
module pixel_skid_buf
  import pixel_fifo_writer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [PIXEL_W-1:0] din,
  output logic               valid,
  output logic [PIXEL_W-1:0] data
);

  // Load has priority over clear so a word is never lost when both are asked for.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/pixel_fifo_writer.sv
// Streams the frame buffer ROM into the display FIFO in row-major order,
// one pixel per cycle, absorbing FIFO backpressure with a one-entry skid.
//
// state    | meaning
// ST_IDLE  | no reads, address held at 0, waiting for enable
// ST_RUN   | issuing ROM reads whenever the skid path can take the data
// ST_DRAIN | frame fully issued with enable low; flushing the last pixels
module pixel_fifo_writer
  import pixel_fifo_writer_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [PIXEL_W-1:0] fifo_wr_data,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [PIXEL_W-1:0] rom_data,
  output logic               frame_start,
  output logic               frame_done
);

  localparam int                FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FRAME_PIXELS - 1);

  wr_state_t          state;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [ADDR_W-1:0]  wr_cnt;
  logic               rd_valid;
  logic               skid_valid;
  logic [PIXEL_W-1:0] skid_data;
  logic               issue;
  logic               write;
  logic               skid_load;
  logic               skid_clear;

  // Issue/write decisions; a read is only issued when its data is sure to land somewhere.
  always_comb begin
    issue      = (state == ST_RUN) && !skid_valid && !(rd_valid && fifo_full);
    write      = (skid_valid || rd_valid) && !fifo_full;
    skid_load  = rd_valid && (fifo_full || skid_valid);
    skid_clear = skid_valid && !fifo_full;
  end

  // Output drive; the skid word is always older than the ROM word, so it goes first.
  always_comb begin
    rom_en       = issue;
    rom_addr     = addr_cnt;
    frame_start  = issue && (addr_cnt == '0);
    fifo_wr_en   = write;
    fifo_wr_data = '0;
    if (write) fifo_wr_data = skid_valid ? skid_data : rom_data;
    frame_done   = write && (wr_cnt == LAST_ADDR);
  end

  // Sequencer and read address counter; enable is only sampled at the end of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_cnt <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= issue;
      case (state)
        ST_IDLE: begin
          addr_cnt <= '0;
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (issue) begin
            if (addr_cnt == LAST_ADDR) begin
              addr_cnt <= '0;
              if (!enable) state <= ST_DRAIN;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          addr_cnt <= '0;
          if (!rd_valid && !skid_valid) state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          addr_cnt <= '0;
        end
      endcase
    end
  end

  // Tracks the frame position of the next pixel written, for the frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (write) begin
      wr_cnt <= (wr_cnt == LAST_ADDR) ? '0 : wr_cnt + 1'b1;
    end
  end

  pixel_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (rom_data),
    .valid (skid_valid),
    .data  (skid_data)
  );

endmodule

// File: tb/tb_pixel_fifo_writer.sv
// Directed bench for pixel_fifo_writer: a 16x8 instance exercises streaming,
// backpressure, random full and reset; a 4x2 instance exercises frame pulses
// and the enable-drop drain.
`timescale 1ns/1ps
module tb_pixel_fifo_writer;

  localparam int LAST_B = 127;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        enable_b = 1'b0;
  logic        fifo_full_b = 1'b0;
  logic        fifo_wr_en_b;
  logic [23:0] fifo_wr_data_b;
  logic        rom_en_b;
  logic [6:0]  rom_addr_b;
  logic [23:0] rom_data_b = '0;
  logic        frame_start_b;
  logic        frame_done_b;

  logic        enable_s = 1'b0;
  logic        fifo_full_s = 1'b0;
  logic        fifo_wr_en_s;
  logic [23:0] fifo_wr_data_s;
  logic        rom_en_s;
  logic [2:0]  rom_addr_s;
  logic [23:0] rom_data_s = '0;
  logic        frame_start_s;
  logic        frame_done_s;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_on = 1'b0;
  int exp_b = 0;
  int frames_seen = 0;

  always #5 clk = ~clk;

  pixel_fifo_writer #(.H_ACTIVE(16), .V_ACTIVE(8), .ADDR_W(7)) dut_big (
    .clk(clk), .rst(rst), .enable(enable_b), .fifo_full(fifo_full_b),
    .fifo_wr_en(fifo_wr_en_b), .fifo_wr_data(fifo_wr_data_b),
    .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .frame_start(frame_start_b), .frame_done(frame_done_b)
  );

  pixel_fifo_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(3)) dut_small (
    .clk(clk), .rst(rst), .enable(enable_s), .fifo_full(fifo_full_s),
    .fifo_wr_en(fifo_wr_en_s), .fifo_wr_data(fifo_wr_data_s),
    .rom_en(rom_en_s), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .frame_start(frame_start_s), .frame_done(frame_done_s)
  );

  // ROM models: data equals address, one cycle after the read strobe.
  always @(posedge clk) if (rom_en_b) rom_data_b <= 24'(rom_addr_b);
  always @(posedge clk) if (rom_en_s) rom_data_s <= 24'(rom_addr_s);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample point: falling edge, plus the scoreboard on the large instance.
  task automatic sample();
    @(negedge clk);
    if (!mon_on) begin
      exp_b = 0;
    end else begin
      chk("b_frame_start", frame_start_b, rom_en_b && (rom_addr_b == 7'd0));
      if (fifo_wr_en_b) begin
        chk("b_order", fifo_wr_data_b, exp_b);
        chk("b_frame_done", frame_done_b, exp_b == LAST_B);
        if (frame_done_b) frames_seen++;
        exp_b = (exp_b + 1) % (LAST_B + 1);
      end else begin
        chk("b_idle_data", fifo_wr_data_b, 0);
        chk("b_idle_done", frame_done_b, 0);
      end
    end
  endtask

  task automatic chk_b_zero(input string tag);
    chk({tag, "_wr_en"}, fifo_wr_en_b, 0);
    chk({tag, "_wr_data"}, fifo_wr_data_b, 0);
    chk({tag, "_rom_en"}, rom_en_b, 0);
    chk({tag, "_rom_addr"}, rom_addr_b, 0);
    chk({tag, "_fstart"}, frame_start_b, 0);
    chk({tag, "_fdone"}, frame_done_b, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int start_frames;
    int issues;
    int writes;
    int fdones;
    int exp_s;

    // Reset state
    repeat (3) begin step(); sample(); end
    chk_b_zero("rst");
    chk("rst_s_rom_en", rom_en_s, 0);
    chk("rst_s_wr_en", fifo_wr_en_s, 0);

    // Streaming with no backpressure, data = address
    step(); rst = 1'b0; enable_b = 1'b1; mon_on = 1'b1; sample();
    chk("idle_no_issue", rom_en_b, 0);
    i = 0;
    while (!rom_en_b && i < 10) begin step(); sample(); i++; end
    chk("first_issue_seen", rom_en_b, 1);
    chk("first_addr", rom_addr_b, 0);
    chk("first_fstart", frame_start_b, 1);
    chk("first_no_write", fifo_wr_en_b, 0);
    step(); sample();
    chk("first_write_en", fifo_wr_en_b, 1);
    chk("first_write_data", fifo_wr_data_b, 0);
    for (int k = 0; k < 20; k++) begin
      step(); sample();
      chk("throughput_wr", fifo_wr_en_b, 1);
      chk("throughput_rd", rom_en_b, 1);
    end

    // Five cycles of full right after address 100 is issued
    i = 0;
    while (!(rom_en_b && rom_addr_b == 7'd100) && i < 400) begin step(); sample(); i++; end
    chk("bp_found_100", rom_addr_b, 100);
    step(); fifo_full_b = 1'b1; sample();
    chk("bp_no_issue", rom_en_b, 0);
    chk("bp_no_write", fifo_wr_en_b, 0);
    for (int k = 0; k < 4; k++) begin
      step(); sample();
      chk("bp_hold_no_issue", rom_en_b, 0);
      chk("bp_hold_no_write", fifo_wr_en_b, 0);
    end
    step(); fifo_full_b = 1'b0; sample();
    chk("bp_resume_en", fifo_wr_en_b, 1);
    chk("bp_resume_data", fifo_wr_data_b, 100);
    chk("bp_resume_no_issue", rom_en_b, 0);
    step(); sample();
    chk("bp_next_issue", rom_en_b, 1);
    chk("bp_next_addr", rom_addr_b, 101);
    step(); sample();
    chk("bp_next_write", fifo_wr_data_b, 101);

    // Random 50% full until three frames complete
    start_frames = frames_seen;
    i = 0;
    while (frames_seen - start_frames < 3 && i < 3000) begin
      step(); fifo_full_b = 1'($urandom_range(0, 1)); sample(); i++;
    end
    chk("rand_frames", frames_seen - start_frames, 3);

    // Reset while the skid holds address 5
    i = 0;
    step(); fifo_full_b = 1'b0; sample();
    while (!(rom_en_b && rom_addr_b == 7'd5) && i < 400) begin step(); sample(); i++; end
    chk("rst_found_5", rom_addr_b, 5);
    step(); fifo_full_b = 1'b1; sample();
    step(); rst = 1'b1; mon_on = 1'b0; sample();
    step(); sample();
    chk_b_zero("midrst");
    step(); rst = 1'b0; fifo_full_b = 1'b0; mon_on = 1'b1; sample();
    i = 0;
    while (!rom_en_b && i < 10) begin step(); sample(); i++; end
    chk("restart_addr", rom_addr_b, 0);
    chk("restart_fstart", frame_start_b, 1);
    step(); sample();
    chk("restart_data", fifo_wr_data_b, 0);
    chk("restart_wr_en", fifo_wr_en_b, 1);
    step(); enable_b = 1'b0; sample();

    // Small 4x2 instance: frame pulses on a continuous stream
    step(); enable_s = 1'b1; sample();
    i = 0;
    while (!rom_en_s && i < 10) begin step(); sample(); i++; end
    for (int k = 0; k <= 8; k++) begin
      chk("s_issue", rom_en_s, 1);
      chk("s_addr", rom_addr_s, k % 8);
      chk("s_fstart", frame_start_s, (k % 8) == 0);
      if (k >= 1) begin
        chk("s_wr_en", fifo_wr_en_s, 1);
        chk("s_data", fifo_wr_data_s, k - 1);
        chk("s_fdone", frame_done_s, k == 8);
      end
      step(); sample();
    end

    // Enable dropped after address 3: frame completes, then drain to idle
    i = 0;
    while (!(rom_en_s && rom_addr_s == 3'd3) && i < 10) begin step(); sample(); i++; end
    chk("s_found_3", rom_addr_s, 3);
    issues = 0; writes = 0; fdones = 0; exp_s = 3;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 0) enable_s = 1'b0;
      sample();
      if (rom_en_s) begin
        chk("s_drain_addr", rom_addr_s, 4 + issues);
        issues++;
      end
      if (fifo_wr_en_s) begin
        chk("s_drain_data", fifo_wr_data_s, exp_s);
        exp_s++;
        writes++;
      end
      if (frame_done_s) begin
        chk("s_drain_fdone_data", fifo_wr_data_s, 7);
        fdones++;
      end
    end
    chk("s_drain_issues", issues, 4);
    chk("s_drain_writes", writes, 5);
    chk("s_drain_fdones", fdones, 1);

    // Re-enable from idle starts a fresh frame at address 0
    step(); enable_s = 1'b1; sample();
    i = 0;
    while (!rom_en_s && i < 10) begin step(); sample(); i++; end
    chk("s_reen_addr", rom_addr_s, 0);
    chk("s_reen_fstart", frame_start_s, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
